rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares one N:1 data mux between N requesters. Each requester has a valid/grant handshake. The arbiter picks a winner, captures the winner's data into a one-deep registered output stage and presents it downstream with a valid/ready handshake. It sits in front of shared datapath resources such as a memory port, writeback bus or functional unit, and drives the select of the shared mux.

Parameters:
- LENGTH, 1: data width per requester in bits.
- N, 2: number of requesters; must be >= 2; need not be a power of 2.
- SEL_BITS, $clog2(N): width of the select/index fields.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  req[i]=1 means requester i holds valid data on p[i].
- p  input  N x LENGTH  per-requester data, packed [N-1:0][LENGTH-1:0].
- grant  output  N  one-hot; grant[i]=1 means p[i] is accepted this cycle.
- sel  output  SEL_BITS  index of the requester whose data is held in q.
- q_valid  output  1  q holds a valid beat.
- q_ready  input  1  downstream accepts q this cycle.
- q  output  LENGTH  registered output data.

Behaviour:
- Reset (async, immediate):
  - q_valid=0, q=0, sel=0.
  - Round-robin pointer ptr=0.
  - grant=0, since it is derived from q_valid and req.
- load = |req & (!q_valid | q_ready). Combinational; the output stage is free or being drained this cycle.
- Winner is the first i with req[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- grant = load ? onehot(winner) : 0. Combinational, same cycle as req. No combinational path from q_ready to grant when q_valid=0.
- Requester handshake:
  - Requester holds req and p stable until it sees grant[i]=1 at a rising edge.
  - Its beat is consumed at that edge.
  - It may keep req=1 for its next beat.
- On load, at the rising edge: q<=p[winner], sel<=winner, q_valid<=1, ptr<=winner+1, wrapping N-1 to 0 (explicit compare, not a power-of-2 wrap).
- q_valid & q_ready & !(|req): q_valid<=0; q and sel hold their values.
- q_valid & !q_ready: q, sel and q_valid hold; grant=0 (back-pressure stalls all requesters).
- Latency: grant edge to q_valid is 1 cycle.
- Throughput: 1 beat per cycle with q_ready held high (drain and reload in the same cycle).
- Fairness:
  - With all N requesting continuously, grants rotate 0,1,...,N-1,0,...
  - No requester waits more than N-1 grants.
- Single persistent requester is granted every cycle that load=1.
- State: EMPTY (q_valid=0) and FULL (q_valid=1).
  - EMPTY to FULL on load.
  - FULL to FULL on (q_ready & |req) or !q_ready.
  - FULL to EMPTY on q_ready & !(|req).
- Reset mid-operation discards the held beat. A requester granted in the same cycle as reset assertion counts as not accepted.
- sel is never >= N.

Optional Feature:
- Macro: ARB_HOLD_EN.
- Enabled:
  - Adds input port req_last (N bits); req_last[i] qualifies req[i].
  - After granting a beat with req_last[winner]=0, the arbiter locks to that requester.
  - While locked, only that requester can win, even if others request and even if it deasserts req; others see grant=0.
  - The lock releases on the granted beat with req_last=1.
  - ptr advances only on that last beat.
  - Reset clears the lock.
- Disabled: no req_last port. Every beat is arbitrated independently; behaviour is as above.

Test Plan:
- Reset mid-stream: N=4, q_valid=1, assert reset asynchronously -> q_valid, q and sel go to 0 immediately, without waiting for a clock edge.
- Rotation: N=4, LENGTH=8, all req=1, p[i]=8'h10+i, q_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; q=10,11,12,13,10 one cycle later; sel matches.
- Back-pressure: req[2]=1 only, q_ready=0 for 3 cycles after the first beat -> q=p[2] held, grant=0 for 3 cycles; then q_ready=1 -> next grant to 2 in the same cycle.
- Non-power-of-2 wrap: N=3, ptr=2, req=3'b011 -> winner 0, ptr becomes 1; then req=3'b111 -> winner 1, then 2, then 0; sel never 3.
- Idle drain: a single beat from requester 1, then req=0, q_ready=1 -> q_valid falls the next cycle; q and sel keep their last values.
- ARB_HOLD_EN: requester 0 sends 3 beats with req_last=0,0,1 while requester 1 requests throughout -> grants 0,0,0,1; ptr is 1 after the third beat.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter driving a shared data mux into a one-deep registered output stage.
// Define ARB_HOLD_EN to add req_last and lock arbitration to one requester for multi-beat bursts.
module rr_mux_arbiter #(
  parameter int LENGTH   = 1,
  parameter int N        = 2,
  parameter int SEL_BITS = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             req,
  input  logic [N-1:0][LENGTH-1:0] p,
`ifdef ARB_HOLD_EN
  input  logic [N-1:0]             req_last,
`endif
  output logic [N-1:0]             grant,
  output logic [SEL_BITS-1:0]      sel,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic [LENGTH-1:0]        q
);

  // state | meaning
  // EMPTY | output stage holds no beat; any request loads it
  // FULL  | q holds a beat; reload only when downstream drains it
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [SEL_BITS:0] N_EXT = (SEL_BITS+1)'(N);

  state_t              state_q, state_d;
  logic [SEL_BITS-1:0] ptr_q, ptr_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic [LENGTH-1:0]   data_q, data_d;
  logic [SEL_BITS-1:0] winner, winner_inc;
  logic [N-1:0]        req_eff;
  logic                any_req, load;

`ifdef ARB_HOLD_EN
  logic                lock_q, lock_d;
  logic [SEL_BITS-1:0] lock_idx_q, lock_idx_d;

  // While locked, only the burst owner is visible to the arbiter.
  always_comb begin
    req_eff = req;
    if (lock_q) req_eff = req & (N'(1) << lock_idx_q);
  end
`else
  assign req_eff = req;
`endif

  always_comb begin : pick
    logic [SEL_BITS:0] idx;
    logic              found;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (SEL_BITS+1)'(k);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!found && req_eff[idx[SEL_BITS-1:0]]) begin
        found  = 1'b1;
        winner = idx[SEL_BITS-1:0];
      end
    end
  end

  assign winner_inc = (winner == SEL_BITS'(N-1)) ? '0 : winner + SEL_BITS'(1);
  assign any_req    = |req_eff;
  assign load       = any_req & ((state_q == EMPTY) | q_ready);

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) grant[i] = load && (winner == SEL_BITS'(i));
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef ARB_HOLD_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
`endif
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (q_ready && !any_req) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (load) begin
      data_d = p[winner];
      sel_d  = winner;
`ifdef ARB_HOLD_EN
      if (req_last[winner]) begin
        ptr_d  = winner_inc;
        lock_d = 1'b0;
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = winner;
      end
`else
      ptr_d = winner_inc;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef ARB_HOLD_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef ARB_HOLD_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  assign q_valid = (state_q == FULL);
  assign q       = data_q;
  assign sel     = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: N=4 and N=3 instances checked every cycle against a round-robin model.
module tb_rr_mux_arbiter;
  logic clk, rst;

  logic [3:0]      req4, grant4, last4;
  logic [3:0][7:0] p4;
  logic [1:0]      sel4;
  logic            qv4, qr4;
  logic [7:0]      q4;

  logic [2:0]      req3, grant3, last3;
  logic [2:0][7:0] p3;
  logic [1:0]      sel3;
  logic            qv3, qr3;
  logic [7:0]      q3;

  int n_checks = 0;
  int n_err    = 0;

`ifdef ARB_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  rr_mux_arbiter #(.LENGTH(8), .N(4)) u4 (
    .clk(clk), .reset(rst), .req(req4), .p(p4),
`ifdef ARB_HOLD_EN
    .req_last(last4),
`endif
    .grant(grant4), .sel(sel4), .q_valid(qv4), .q_ready(qr4), .q(q4)
  );

  rr_mux_arbiter #(.LENGTH(8), .N(3)) u3 (
    .clk(clk), .reset(rst), .req(req3), .p(p3),
`ifdef ARB_HOLD_EN
    .req_last(last3),
`endif
    .grant(grant3), .sel(sel3), .q_valid(qv3), .q_ready(qr3), .q(q3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state per instance (0: N=4, 1: N=3); lock -1 means unlocked.
  int m_ptr[2]  = '{0, 0};
  int m_sel[2]  = '{0, 0};
  int m_q[2]    = '{0, 0};
  int m_lock[2] = '{-1, -1};
  bit m_v[2]    = '{1'b0, 1'b0};

  function automatic int pick(int k, int n, int reqv);
    if (m_lock[k] >= 0) return (((reqv >> m_lock[k]) & 1) != 0) ? m_lock[k] : -1;
    for (int j = 0; j < n; j++) begin
      int i;
      i = (m_ptr[k] + j) % n;
      if (((reqv >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  function automatic int exp_win(int k, int n, int reqv, bit ready);
    if (m_v[k] && !ready) return -1;
    return pick(k, n, reqv);
  endfunction

  task automatic model_load(int k, int n, int w, int lastv, int data);
    m_q[k]   = data;
    m_sel[k] = w;
    m_v[k]   = 1'b1;
    if (HOLD && ((lastv >> w) & 1) == 0) m_lock[k] = w;
    else begin
      m_lock[k] = -1;
      m_ptr[k]  = (w + 1) % n;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_ptr[k] = 0; m_sel[k] = 0; m_q[k] = 0; m_lock[k] = -1; m_v[k] = 1'b0;
      end
    end else begin
      w = exp_win(0, 4, int'(req4), qr4);
      if (w >= 0) model_load(0, 4, w, int'(last4), int'(p4[w]));
      else if (m_v[0] && qr4) m_v[0] = 1'b0;
      w = exp_win(1, 3, int'(req3), qr3);
      if (w >= 0) model_load(1, 3, w, int'(last3), int'(p3[w]));
      else if (m_v[1] && qr3) m_v[1] = 1'b0;
    end
  end

  always @(negedge clk) begin
    int e0, e1;
    if (!rst) begin
      e0 = exp_win(0, 4, int'(req4), qr4);
      e1 = exp_win(1, 3, int'(req3), qr3);
      chk("u4.grant",   32'(grant4), (e0 >= 0) ? (32'd1 << e0) : 32'd0);
      chk("u4.q_valid", 32'(qv4),    32'(m_v[0]));
      chk("u4.q",       32'(q4),     32'(m_q[0]));
      chk("u4.sel",     32'(sel4),   32'(m_sel[0]));
      chk("u3.grant",   32'(grant3), (e1 >= 0) ? (32'd1 << e1) : 32'd0);
      chk("u3.q_valid", 32'(qv3),    32'(m_v[1]));
      chk("u3.q",       32'(q3),     32'(m_q[1]));
      chk("u3.sel",     32'(sel3),   32'(m_sel[1]));
    end
  end

  int rot_g[5] = '{1, 2, 4, 8, 1};
  int rot_q[4] = '{'h10, 'h11, 'h12, 'h13};
  int rot_s[4] = '{0, 1, 2, 3};
  int hold_g[4] = '{1, 1, 1, 2};
  int hold_l[4] = '{0, 0, 1, 3};
  int wrap_g[3] = '{2, 4, 1};

  initial begin
    rst = 1'b0;
    req4 = '0; last4 = '1; p4 = '0; qr4 = 1'b1;
    req3 = '0; last3 = '1; p3 = '0; qr3 = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst.q_valid", 32'(qv4), 0);
    chk("rst.q",       32'(q4), 0);
    chk("rst.sel",     32'(sel4), 0);
    chk("rst.grant",   32'(grant4), 0);
    @(posedge clk); #1 rst = 1'b0;

    // rotation with all four requesting
    for (int i = 0; i < 4; i++) p4[i] = 8'h10 + 8'(i);
    req4 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rot.grant", 32'(grant4), 32'(rot_g[i]));
      if (i > 0) begin
        chk("rot.q",   32'(q4),   32'(rot_q[i-1]));
        chk("rot.sel", 32'(sel4), 32'(rot_s[i-1]));
      end
      @(posedge clk);
    end
    #1;
    chk("rot.q_last",   32'(q4),   'h10);
    chk("rot.sel_last", 32'(sel4), 0);

    // back-pressure on a single requester
    req4 = 4'b0100; p4[2] = 8'hA5;
    @(negedge clk); chk("bp.first_grant", 32'(grant4), 4);
    @(posedge clk); #1 qr4 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp.stall_grant", 32'(grant4), 0);
      chk("bp.stall_q",     32'(q4), 'hA5);
      chk("bp.stall_sel",   32'(sel4), 2);
      chk("bp.stall_valid", 32'(qv4), 1);
      @(posedge clk);
    end
    #1 qr4 = 1'b1;
    @(negedge clk); chk("bp.resume_grant", 32'(grant4), 4);

    // single beat from requester 1, then idle drain
    @(posedge clk); #1 req4 = 4'b0010; p4[1] = 8'h3C;
    @(negedge clk); chk("idle.grant", 32'(grant4), 2);
    @(posedge clk); #1 req4 = '0;
    @(negedge clk);
    chk("idle.valid_hi", 32'(qv4), 1);
    chk("idle.q",        32'(q4), 'h3C);
    chk("idle.no_grant", 32'(grant4), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle.valid_lo", 32'(qv4), 0);
    chk("idle.q_hold",   32'(q4), 'h3C);
    chk("idle.sel_hold", 32'(sel4), 1);

    // asynchronous reset while a beat is held
    @(posedge clk); #1 req4 = 4'hF;
    @(posedge clk); #1 req4 = '0;
    chk("mid.pre_valid", 32'(qv4), 1);
    chk("mid.pre_q",     32'(q4), 'hA5);
    #1 rst = 1'b1;
    #1;
    chk("mid.valid", 32'(qv4), 0);
    chk("mid.q",     32'(q4), 0);
    chk("mid.sel",   32'(sel4), 0);
    @(posedge clk); #1 rst = 1'b0;

`ifdef ARB_HOLD_EN
    // three-beat burst from requester 0 while requester 1 waits
    req4 = 4'b0011; p4[0] = 8'hC0; p4[1] = 8'hC1;
    for (int i = 0; i < 4; i++) begin
      last4 = 4'(hold_l[i]);
      @(negedge clk); chk("hold.grant", 32'(grant4), 32'(hold_g[i]));
      @(posedge clk); #1;
    end
    req4 = '0; last4 = '1;
`endif

    // non-power-of-2 wrap on the N=3 instance
    p3 = {8'h22, 8'h21, 8'h20};
    req3 = 3'b010;
    @(negedge clk); chk("wrap.first", 32'(grant3), 2);
    @(posedge clk); #1 req3 = 3'b011;
    @(negedge clk); chk("wrap.from2", 32'(grant3), 1);
    @(posedge clk); #1 req3 = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("wrap.grant", 32'(grant3), 32'(wrap_g[i]));
      @(posedge clk);
    end
    #1 req3 = '0;
    @(negedge clk);
    chk("wrap.sel", 32'(sel3), 0);
    chk("wrap.q",   32'(q3), 'h20);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
